kbd_event_queue: RTL and testbench

Parametrised keyboard front-end for the virtio-input keyboard device. Takes raw PS/2 set-2 bytes from the PS/2 or CH559 serial receiver and decodes the F0 (break), E0 (extended) and E1 (Pause) prefixes. Pushes complete key events into a DEPTH-entry FIFO, which the micro-controller drains through a valid/ready handshake. Generates a paced interrupt request while events are pending, and reports occupancy and a sticky overflow flag.

---
 rtl/kbd_event_queue.sv | 260 ++++++++++++++++++++++++++
 tb/tb_kbd_event_queue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_event_queue.sv
// kbd_event_queue
// ---------------------------------------------------------------------------
// Keyboard front-end for the virtio-input keyboard device. Raw PS/2 set-2
// bytes are decoded (F0 break, E0 extended, E1 Pause prefixes) into key
// events, which are queued in a DEPTH-entry first-word-fall-through FIFO and
// drained by the micro-controller with a valid/ready handshake. A paced
// interrupt request is raised while events are pending.
//
// Optional feature (compile-time macro): KBD_TYPEMATIC_FILTER_EN
//   When defined, a 512-bit pressed-key bitmap indexed by {ext, code}
//   suppresses typematic repeats of keys that are already held down.
//
// Parameters:
//   DEPTH      FIFO entries, power of 2, 2..256
//   IRQ_PERIOD cycles between interrupt opportunities, >= 2
//   E1_SKIP    bytes discarded after an E1 prefix
//
// Ports:
//   CLK        clock
//   RST_X      synchronous active-low reset
//   rx_en      one-cycle strobe, rx_data valid
//   rx_data    received scancode byte
//   ev_valid   FIFO head valid
//   ev_data    head event {6'b0, extended, press, code}; 0 when empty
//   ev_ready   pop head when ev_valid && ev_ready
//   irq_en     interrupt pacing enable
//   irq_req    one-cycle interrupt request pulse
//   count      entries held
//   ovf        sticky overflow (event dropped while full)
//   ovf_clr    clears ovf
// ---------------------------------------------------------------------------
module kbd_event_queue #(
    parameter int DEPTH      = 16,
    parameter int IRQ_PERIOD = 262144,
    parameter int E1_SKIP    = 7
) (
    input  logic                     CLK,
    input  logic                     RST_X,
    input  logic                     rx_en,
    input  logic [7:0]               rx_data,
    output logic                     ev_valid,
    output logic [15:0]              ev_data,
    input  logic                     ev_ready,
    input  logic                     irq_en,
    output logic                     irq_req,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(IRQ_PERIOD);
    localparam int SW = (E1_SKIP > 0) ? $clog2(E1_SKIP + 1) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_BRK     = 3'd1;
    localparam logic [2:0] ST_EXT     = 3'd2;
    localparam logic [2:0] ST_EXT_BRK = 3'd3;
    localparam logic [2:0] ST_SKIP    = 3'd4;

    // ------------------------------------------------------------------
    // Scancode decoder
    // ------------------------------------------------------------------
    logic [2:0]    state_q, state_d;
    logic [SW-1:0] skip_q, skip_d;
    logic          dec_push;
    logic          dec_ext;
    logic          dec_press;
    logic [9:0]    dec_word;

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        dec_push  = 1'b0;
        dec_ext   = 1'b0;
        dec_press = 1'b0;
        if (rx_en) begin
            case (state_q)
                ST_IDLE: begin
                    case (rx_data)
                        8'hF0: state_d = ST_BRK;
                        8'hE0: state_d = ST_EXT;
                        8'hE1: begin
                            // With nothing to skip the Pause prefix is simply dropped.
                            if (E1_SKIP > 0) begin
                                state_d = ST_SKIP;
                                skip_d  = SW'(E1_SKIP);
                            end
                        end
                        // Controller replies (ACK, BAT, resend, errors) are not keys.
                        8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: ;
                        default: begin
                            dec_push  = 1'b1;
                            dec_press = 1'b1;
                        end
                    endcase
                end
                ST_BRK: begin
                    dec_push = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_data != 8'hE0) begin
                        dec_push  = 1'b1;
                        dec_ext   = 1'b1;
                        dec_press = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    dec_push = 1'b1;
                    dec_ext  = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_d = skip_q - 1'b1;
                    if (skip_q <= SW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign dec_word = {dec_ext, dec_press, rx_data};

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          not_empty;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == (AW + 1)'(DEPTH));
    assign pop       = not_empty && ev_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok   = push_req && (!full || pop);

`ifdef KBD_TYPEMATIC_FILTER_EN
    logic [511:0] pressed_q, pressed_d;
    logic [8:0]   key_idx;

    assign key_idx  = {dec_ext, rx_data};
    // A press of a key already held down is an autorepeat: drop it silently.
    assign push_req = dec_push && !(dec_press && pressed_q[key_idx]);

    always_comb begin
        pressed_d = pressed_q;
        if (dec_push && !dec_press) begin
            pressed_d[key_idx] = 1'b0;
        end else if (push_ok && dec_press) begin
            // Only a press that actually entered the queue marks the key held.
            pressed_d[key_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            pressed_q <= '0;
        end else begin
            pressed_q <= pressed_d;
        end
    end
`else
    assign push_req = dec_push;
`endif

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push_ok) begin
            tail_d = tail_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A fresh overflow wins over a clear in the same cycle.
        ovf_d = (ovf_q && !ovf_clr) || (push_req && full && !pop);
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Event storage; only 10 bits carry information, the upper 6 are zero.
    logic [9:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[tail_q] <= dec_word;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt pacing
    // ------------------------------------------------------------------
    logic [TW-1:0] timer_q, timer_d;
    logic          timer_wrap;
    logic          irq_q;

    assign timer_wrap = (timer_q == TW'(IRQ_PERIOD - 1));
    assign timer_d    = timer_wrap ? '0 : timer_q + 1'b1;

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            timer_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            irq_q   <= timer_wrap && irq_en && not_empty;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registered state
    // ------------------------------------------------------------------
    assign ev_valid = not_empty;
    // Forced to zero when empty so stale storage never shows after reset.
    assign ev_data  = not_empty ? {6'b0, mem[head_q]} : 16'h0000;
    assign irq_req  = irq_q;
    assign count    = count_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_kbd_event_queue.sv
module tb_kbd_event_queue;

    localparam int DEPTH      = 4;
    localparam int IRQ_PERIOD = 8;
    localparam int E1_SKIP    = 7;
`ifdef KBD_TYPEMATIC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        CLK;
    logic        RST_X;
    logic        rx_en;
    logic [7:0]  rx_data;
    logic        ev_valid;
    logic [15:0] ev_data;
    logic        ev_ready;
    logic        irq_en;
    logic        irq_req;
    logic [2:0]  count;
    logic        ovf;
    logic        ovf_clr;

    kbd_event_queue #(
        .DEPTH      (DEPTH),
        .IRQ_PERIOD (IRQ_PERIOD),
        .E1_SKIP    (E1_SKIP)
    ) dut (
        .CLK      (CLK),
        .RST_X    (RST_X),
        .rx_en    (rx_en),
        .rx_data  (rx_data),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ev_ready (ev_ready),
        .irq_en   (irq_en),
        .irq_req  (irq_req),
        .count    (count),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [15:0] sb [$];
    logic [15:0] mon_exp;

    typedef struct {
        logic [7:0]  b;
        bit          push;
        logic [15:0] ev;
    } vec_t;
    vec_t vt [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_en   = 1'b1;
        tick();
        rx_en   = 1'b0;
        $display("rx %02h count=%0d", b, count);
    endtask

    task automatic add_vec(input logic [7:0] b, input bit push, input logic [15:0] ev);
        vec_t v;
        v.b    = b;
        v.push = push;
        v.ev   = ev;
        vt.push_back(v);
    endtask

    task automatic drain(input string name);
        ev_ready = 1'b1;
        for (int i = 0; i < 100 && (ev_valid || sb.size() != 0); i++) begin
            tick();
        end
        ev_ready = 1'b0;
        check({name, "_sb_empty"}, sb.size(), 0);
        check({name, "_valid_low"}, ev_valid, 0);
    endtask

    // Scoreboard consumer: the head is popped on the next rising edge.
    always @(negedge CLK) begin
        if (RST_X && ev_valid && ev_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got %04h expected none", ev_data);
            end else begin
                mon_exp = sb.pop_front();
                $display("pop %04h expected %04h", ev_data, mon_exp);
                check("event", ev_data, mon_exp);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    int pulses;
    int pulse_at [$];
    logic [7:0] code;

    initial begin
        RST_X    = 1'b0;
        rx_en    = 1'b0;
        rx_data  = 8'h00;
        ev_ready = 1'b0;
        irq_en   = 1'b0;
        ovf_clr  = 1'b0;
        tick(); tick(); tick();

        // Reset state
        check("rst_valid", ev_valid, 0);
        check("rst_data", ev_data, 0);
        check("rst_count", count, 0);
        check("rst_irq", irq_req, 0);
        check("rst_ovf", ovf, 0);
        RST_X = 1'b1;
        tick();

        // Make then break, held in the queue
        send_byte(8'h1C);
        check("t1_count1", count, 1);
        send_byte(8'hF0);
        check("t1_count_prefix", count, 1);
        send_byte(8'h1C);
        check("t1_count2", count, 2);
        check("t1_head", ev_data, 16'h011C);
        sb.push_back(16'h011C);
        sb.push_back(16'h001C);
        ev_ready = 1'b1;
        tick();
        tick();
        ev_ready = 1'b0;
        check("t1_valid_after_pops", ev_valid, 0);
        check("t1_count_after_pops", count, 0);

        // Vector table: extended keys, Pause skip, controller replies, typematic
        add_vec(8'hE0, 0, 16'h0);
        add_vec(8'h75, 1, 16'h0375);
        add_vec(8'hE0, 0, 16'h0);
        add_vec(8'hF0, 0, 16'h0);
        add_vec(8'h75, 1, 16'h0275);
        add_vec(8'hE1, 0, 16'h0);
        add_vec(8'h14, 0, 16'h0);
        add_vec(8'h77, 0, 16'h0);
        add_vec(8'hE1, 0, 16'h0);
        add_vec(8'hF0, 0, 16'h0);
        add_vec(8'h14, 0, 16'h0);
        add_vec(8'hF0, 0, 16'h0);
        add_vec(8'h77, 0, 16'h0);
        add_vec(8'h1C, 1, 16'h011C);
        add_vec(8'hF0, 0, 16'h0);
        add_vec(8'h1C, 1, 16'h001C);
        add_vec(8'hAA, 0, 16'h0);
        add_vec(8'hFA, 0, 16'h0);
        add_vec(8'h00, 0, 16'h0);
        add_vec(8'hFE, 0, 16'h0);
        add_vec(8'hFF, 0, 16'h0);
        add_vec(8'hE0, 0, 16'h0);
        add_vec(8'hE0, 0, 16'h0);
        add_vec(8'h12, 1, 16'h0312);
        add_vec(8'hE0, 0, 16'h0);
        add_vec(8'hF0, 0, 16'h0);
        add_vec(8'h12, 1, 16'h0212);
        add_vec(8'h1C, 1, 16'h011C);
        add_vec(8'h1C, !FILT, 16'h011C);
        add_vec(8'h1C, !FILT, 16'h011C);
        add_vec(8'hF0, 0, 16'h0);
        add_vec(8'h1C, 1, 16'h001C);
        add_vec(8'h1C, 1, 16'h011C);
        add_vec(8'hF0, 0, 16'h0);
        add_vec(8'h1C, 1, 16'h001C);

        ev_ready = 1'b1;
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].push) sb.push_back(vt[i].ev);
            send_byte(vt[i].b);
        end
        drain("table");

        // Overflow at full, push+pop at full, ovf clear and clear/overflow collision
        for (int i = 0; i < DEPTH + 1; i++) begin
            code = FILT ? 8'(8'h15 + i) : 8'h15;
            send_byte(code);
            if (i < DEPTH) sb.push_back({8'h01, code});
        end
        check("t3_count_full", count, DEPTH);
        check("t3_ovf_set", ovf, 1);
        check("t3_head", ev_data, 16'h0115);
        code = FILT ? 8'h1A : 8'h15;
        sb.push_back({8'h01, code});
        ev_ready = 1'b1;
        send_byte(code);
        ev_ready = 1'b0;
        check("t3_count_pushpop", count, DEPTH);
        check("t3_ovf_held", ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t3_ovf_cleared", ovf, 0);
        ovf_clr = 1'b1;
        send_byte(FILT ? 8'h1B : 8'h15);
        ovf_clr = 1'b0;
        check("t3_ovf_collision", ovf, 1);
        check("t3_count_after_drop", count, DEPTH);
        drain("t3");
        // The dropped press must not have marked its key as held
        sb.push_back(16'h0119);
        send_byte(8'h19);
        drain("t3_dropped_key");

        // Interrupt pacing
        sb.push_back(16'h012B);
        send_byte(8'h2B);
        irq_en = 1'b1;
        tick();
        pulses = 0;
        pulse_at.delete();
        for (int i = 0; i < 32; i++) begin
            tick();
            if (irq_req) begin
                pulses++;
                pulse_at.push_back(i);
                $display("irq pulse at cycle %0d", i);
            end
        end
        check("t4_pulse_count", pulses, 4);
        for (int k = 1; k < pulse_at.size(); k++) begin
            check("t4_pulse_spacing", pulse_at[k] - pulse_at[k-1], IRQ_PERIOD);
        end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("t4_count_after_pop", count, 0);
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (irq_req) pulses++;
        end
        check("t4_no_pulse_empty", pulses, 0);
        irq_en = 1'b0;
        sb.push_back(16'h012C);
        send_byte(8'h2C);
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (irq_req) pulses++;
        end
        check("t4_no_pulse_disabled", pulses, 0);
        drain("t4");

        // Reset mid-prefix with a full, overflowed queue and irq enabled
        irq_en = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_byte(8'(8'h31 + i));
        end
        for (int i = 0; i < IRQ_PERIOD; i++) tick();
        send_byte(8'hF0);
        RST_X = 1'b0;
        tick();
        check("t5_rst_valid", ev_valid, 0);
        check("t5_rst_data", ev_data, 0);
        check("t5_rst_count", count, 0);
        check("t5_rst_ovf", ovf, 0);
        check("t5_rst_irq", irq_req, 0);
        tick();
        RST_X  = 1'b1;
        irq_en = 1'b0;
        sb.push_back(16'h011C);
        send_byte(8'h1C);
        check("t5_count", count, 1);
        drain("t5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
